fetch_stage_buffered: RTL
=========================

Name: fetch_stage_buffered

Overview:
Parametrised IF stage plus IF/ID pipeline register, generalising the fixed 32-bit single-cycle fetch. It talks to instruction memory through a request/response handshake with variable latency. A DEPTH-entry prefetch buffer absorbs that latency. The block supports decode stall, decode flush and execute-stage redirect, with wrong-path response squashing. It sits between the PC/branch logic of EX and the decode stage of the RISC-V pipeline.

Parameters:
XLEN, 32, address/instruction width (must be >= 32; instructions use the low 32 bits, upper bits zero)
RESET_PC, 0, PC value loaded on reset
DEPTH, 2, prefetch buffer entries, also the max outstanding requests (power of 2, >= 2)
NOP_INSTR, 32'h00000013, bubble instruction driven on instr_d when invalid

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
pc_src_e  in  1  redirect request from EX
pc_target_e  in  XLEN  redirect target
stall_d  in  1  hold IF/ID register (hazard unit)
flush_d  in  1  invalidate IF/ID register
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address
imem_rsp_valid  in  1  response valid (in order, no backpressure)
imem_rsp_data  in  32  fetched instruction
instr_d  out  32  instruction to decode
pc_d  out  XLEN  PC of instr_d
pc_plus4_d  out  XLEN  pc_d + 4
valid_d  out  1  instr_d is real

Behaviour:
- Reset (rst=0, async):
  - pc_f=RESET_PC; buffer empty; outstanding=0; drop=0.
  - valid_d=0, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0.
  - imem_req_valid=0 while in reset.
- Request issue:
  - imem_req_valid=1 iff (buf_count + outstanding) < DEPTH and pc_src_e=0.
  - imem_req_addr=pc_f.
  - On valid&ready: pc_f <= pc_f+4 (mod 2^XLEN wrap), outstanding+1.
- Response:
  - Each imem_rsp_valid decrements outstanding.
  - If drop>0, the response is discarded and drop decrements.
  - Otherwise {data, pc, pc+4} is pushed into the buffer. The PC comes from a DEPTH-deep in-order queue of issued addresses.
  - Overflow is impossible by the credit rule above; assert on overflow in simulation.
- Redirect (pc_src_e=1), highest priority, single cycle:
  - pc_f <= pc_target_e.
  - Buffer cleared.
  - drop <= outstanding minus any response arriving in this same cycle (that response is also discarded).
  - IF/ID loaded with bubble (valid_d=0, instr_d=NOP_INSTR) regardless of stall_d.
  - No request is issued that cycle. The first request to the target is issued the next cycle.
- IF/ID register update (when no redirect):
  - flush_d=1: bubble loaded; the buffer head is not popped.
  - else stall_d=1: hold all outputs; no pop.
  - else if buffer non-empty: pop the head into instr_d/pc_d/pc_plus4_d with valid_d=1.
  - else buffer empty: bubble loaded.
  - Simultaneous push and pop on the buffer is allowed.
  - Bypass is not allowed: response-to-decode latency is 1 cycle minimum (response at edge N is written to the buffer, reaches the outputs at edge N+1).
- Outputs are registered. No combinational path from imem_rsp_* to the *_d outputs.
- pc_plus4_d is computed at issue time, XLEN-bit, wraps.
- Misaligned pc_target_e (bits[1:0]!=0) is passed through unchanged. Trap handling is not the responsibility of this block.

Test Plan:
- Reset then release, memory ready=1 with 1-cycle latency, returning data=addr^32'hA5A50000 -> requests at 0,4,8..., valid_d rises 3 edges after release; pc_d=0,4,8 in consecutive cycles; pc_plus4_d=pc_d+4.
- Memory ready toggling 1/0, latency 3 cycles, DEPTH=2 -> never more than 2 in flight+buffered; no lost or duplicated PCs; every pc_d/instr_d pair is consistent.
- Redirect to 32'h00000100 with 2 requests outstanding -> both responses dropped; next valid_d shows pc_d=0x100; no instr_d from the old path ever has valid_d=1.
- stall_d held 4 cycles mid-stream -> outputs frozen; after release the sequence resumes without a gap or repeat. flush_d for 1 cycle -> one bubble (valid_d=0, instr_d=0x00000013), next PC is not skipped.
- Redirect coincident with stall_d=1 and a response arriving -> bubble loaded, response discarded, fetch restarts at the target.
- Async reset asserted mid-stream with 1 request outstanding -> outputs zero/NOP immediately; after release fetch restarts at RESET_PC. The bench drops the stale response. Also check the PC wraps from 0xFFFFFFFC to 0.

Source files
------------

// File: rtl/fetch_stage_buffered.sv
// Fetch stage with IF/ID register. Talks to instruction memory through a
// valid/ready request channel and an in-order response channel. A small
// prefetch FIFO absorbs the memory latency, and decode sees only registered outputs.
module fetch_stage_buffered #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int unsigned     DEPTH     = 2,
   parameter logic [31:0]     NOP_INSTR = 32'h00000013
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pc_src_e,
   input  logic [XLEN-1:0] pc_target_e,
   input  logic            stall_d,
   input  logic            flush_d,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic [31:0]     instr_d,
   output logic [XLEN-1:0] pc_d,
   output logic [XLEN-1:0] pc_plus4_d,
   output logic            valid_d
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pcPlus4;
   } pcPair_t;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pcPlus4;
   } fetchEntry_t;

   logic [XLEN-1:0] pcF;

   // Addresses of issued requests. Responses come back in order, so each one pops the head.
   pcPair_t         pcQ [DEPTH];
   logic [PW-1:0]   pcQHead, pcQTail;

   // Prefetch FIFO holding returned instructions until decode takes them.
   fetchEntry_t     fifoMem [DEPTH];
   logic [PW-1:0]   fifoRd, fifoWr;
   logic [CW-1:0]   fifoCount;

   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   dropCnt;

   logic [CW:0]     inFlight;
   logic            reqFire;
   logic            rspDrop;
   logic            bufPush;
   logic            bufPop;

   fetchEntry_t     ifId;
   logic            ifIdValid;

   // A request is issued only while total occupancy (buffered + in flight)
   // leaves room. This credit rule is what makes FIFO overflow impossible.
   always_comb begin
      inFlight       = {1'b0, fifoCount} + {1'b0, outstanding};
      imem_req_valid = rst & ~pc_src_e & (inFlight < DEPTH_C);
      imem_req_addr  = pcF;
      reqFire        = imem_req_valid & imem_req_ready;
      rspDrop        = imem_rsp_valid & (pc_src_e | (dropCnt != '0));
      bufPush        = imem_rsp_valid & ~rspDrop;
      bufPop         = ~pc_src_e & ~flush_d & ~stall_d & (fifoCount != '0);
   end

   // Fetch PC: redirect overrides, otherwise advance on each accepted request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pcF <= RESET_PC;
      end else if (pc_src_e) begin
         pcF <= pc_target_e;
      end else if (reqFire) begin
         pcF <= pcF + XLEN'(4);
      end
   end

   // Issued-address queue pointers. These keep running across redirects so
   // stale responses still line up with their own entries.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pcQHead <= '0;
         pcQTail <= '0;
      end else begin
         if (reqFire)        pcQTail <= pcQTail + PW'(1);
         if (imem_rsp_valid) pcQHead <= pcQHead + PW'(1);
      end
   end

   // Issued-address queue storage. pc+4 is computed here, at issue time.
   always_ff @(posedge clk) begin
      if (reqFire) pcQ[pcQTail] <= '{pc: pcF, pcPlus4: pcF + XLEN'(4)};
   end

   // Outstanding and wrong-path drop counters. On a redirect, every request
   // still in flight belongs to the old path, except one answered this same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         outstanding <= '0;
         dropCnt     <= '0;
      end else begin
         outstanding <= outstanding + CW'(reqFire) - CW'(imem_rsp_valid);
         if (pc_src_e)
            dropCnt <= outstanding - CW'(imem_rsp_valid);
         else if (imem_rsp_valid && dropCnt != '0)
            dropCnt <= dropCnt - CW'(1);
      end
   end

   // Prefetch FIFO control. A redirect empties it; push and pop may happen in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fifoRd    <= '0;
         fifoWr    <= '0;
         fifoCount <= '0;
      end else if (pc_src_e) begin
         fifoRd    <= '0;
         fifoWr    <= '0;
         fifoCount <= '0;
      end else begin
         if (bufPush) fifoWr <= fifoWr + PW'(1);
         if (bufPop)  fifoRd <= fifoRd + PW'(1);
         fifoCount <= fifoCount + CW'(bufPush) - CW'(bufPop);
      end
   end

   // Prefetch FIFO storage. The response is tagged with the PC of its request.
   always_ff @(posedge clk) begin
      if (bufPush)
         fifoMem[fifoWr] <= '{instr:   imem_rsp_data,
                              pc:      pcQ[pcQHead].pc,
                              pcPlus4: pcQ[pcQHead].pcPlus4};
   end

   // IF/ID register. Priority is redirect, then flush, then stall, then pop.
   // It only reads the FIFO, so a response reaches decode one edge after it is written at the earliest.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ifIdValid <= 1'b0;
         ifId      <= '{instr: NOP_INSTR, pc: '0, pcPlus4: '0};
      end else if (pc_src_e || flush_d) begin
         ifIdValid  <= 1'b0;
         ifId.instr <= NOP_INSTR;
      end else if (!stall_d) begin
         if (fifoCount != '0) begin
            ifIdValid <= 1'b1;
            ifId      <= fifoMem[fifoRd];
         end else begin
            ifIdValid  <= 1'b0;
            ifId.instr <= NOP_INSTR;
         end
      end
   end

   assign instr_d    = ifId.instr;
   assign pc_d       = ifId.pc;
   assign pc_plus4_d = ifId.pcPlus4;
   assign valid_d    = ifIdValid;

   // The credit rule must keep the FIFO from ever overflowing.
   assert property (@(posedge clk) disable iff (!rst)
      !(bufPush && !bufPop && fifoCount == CW'(DEPTH)));

   // A response must never arrive with no request outstanding.
   assert property (@(posedge clk) disable iff (!rst)
      !(imem_rsp_valid && outstanding == '0));

endmodule
